// File: rtl/ultrasonic_ranger.sv
`default_nettype none
// ============================================================================
// Module      : ultrasonic_ranger
// Description : HC-SR04 front-end. Issues periodic trigger pulses, times the
//               synchronised echo pulse, converts it to centimetres and
//               exposes the results through a 32-bit Avalon-MM slave.
// Ports       : clk_clk, reset_reset_n  - clock, async active-low reset
//               echo / trig             - sensor interface
//               avs_*                   - Avalon-MM slave, read latency 1
//               irq                     - level interrupt (valid & irq_en)
// Revision    : 1.0 - initial release
// ============================================================================
module ultrasonic_ranger #(
    parameter int unsigned TRIG_CYCLES    = 500,
    parameter int unsigned PERIOD_CYCLES  = 3000000,
    parameter int unsigned TIMEOUT_CYCLES = 1500000,
    parameter int unsigned CM_DIV         = 2900
) (
    input  logic        clk_clk,
    input  logic        reset_reset_n,
    input  logic        echo,
    output logic        trig,
    input  logic [1:0]  avs_address,
    input  logic        avs_read,
    input  logic        avs_write,
    input  logic [31:0] avs_writedata,
    output logic [31:0] avs_readdata,
    output logic        irq
);

    localparam int unsigned c_SUB_W = (CM_DIV > 1) ? $clog2(CM_DIV) : 1;

    localparam logic [2:0] c_IDLE      = 3'd0;
    localparam logic [2:0] c_TRIG      = 3'd1;
    localparam logic [2:0] c_WAIT_RISE = 3'd2;
    localparam logic [2:0] c_MEASURE   = 3'd3;
    localparam logic [2:0] c_HOLDOFF   = 3'd4;

    logic [2:0]         r_state;
    logic [2:0]         w_state_nxt;
    logic               w_timeout_set;
    logic               w_result;

    logic               r_echo_m, r_echo_s, r_echo_d;
    logic               w_rise, w_fall;

    logic [31:0]        r_cyc_cnt;
    logic [31:0]        r_period_cnt;
    logic [23:0]        r_echo_cnt;
    logic [c_SUB_W-1:0] r_sub;
    logic [15:0]        r_cm;
    logic [23:0]        w_echo_inc;
    logic               w_sub_wrap;
    logic [c_SUB_W-1:0] w_sub_inc;
    logic [15:0]        w_cm_inc;

    logic               r_enable, r_irq_en, r_valid, r_timeout, r_trig;
    logic [15:0]        r_dist_cm;
    logic [23:0]        r_echo_cyc;
    logic [15:0]        r_meas_cnt;
    logic               w_ctrl_wr, w_dist_rd;
    logic               w_unused;

    assign w_unused = ^{avs_writedata[31:10], avs_writedata[8:2]};

    // Echo synchroniser plus one delay stage for edge detection.
    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            r_echo_m <= 1'b0;
            r_echo_s <= 1'b0;
            r_echo_d <= 1'b0;
        end else begin
            r_echo_m <= echo;
            r_echo_s <= r_echo_m;
            r_echo_d <= r_echo_s;
        end
    end

    assign w_rise = r_echo_s & ~r_echo_d;
    assign w_fall = ~r_echo_s & r_echo_d;

    // The capture on fall includes the current cycle, so the stored width
    // equals the number of cycles echo_s was high and cm = floor(width/CM_DIV).
    assign w_echo_inc = (r_echo_cnt == 24'hFFFFFF) ? r_echo_cnt : r_echo_cnt + 24'd1;
    assign w_sub_wrap = (r_sub == c_SUB_W'(CM_DIV - 1));
    assign w_sub_inc  = w_sub_wrap ? '0 : r_sub + 1'b1;
    assign w_cm_inc   = (w_sub_wrap && r_cm != 16'hFFFF) ? r_cm + 16'd1 : r_cm;

    always_comb begin
        w_state_nxt   = r_state;
        w_timeout_set = 1'b0;
        w_result      = 1'b0;
        case (r_state)
            c_IDLE: begin
                if (r_enable) w_state_nxt = c_TRIG;
            end
            c_TRIG: begin
                if (r_cyc_cnt == TRIG_CYCLES - 1) w_state_nxt = c_WAIT_RISE;
            end
            c_WAIT_RISE: begin
                if (w_rise) begin
                    w_state_nxt = c_MEASURE;
                end else if (r_cyc_cnt == TIMEOUT_CYCLES - 1) begin
                    w_timeout_set = 1'b1;
                    w_state_nxt   = c_HOLDOFF;
                end
            end
            c_MEASURE: begin
                if (w_fall) begin
                    w_result    = 1'b1;
                    w_state_nxt = c_HOLDOFF;
                end else if ({8'd0, w_echo_inc} >= TIMEOUT_CYCLES) begin
                    w_timeout_set = 1'b1;
                    w_state_nxt   = c_HOLDOFF;
                end
            end
            c_HOLDOFF: begin
                // >= covers a measurement that overran the period.
                if (r_period_cnt >= PERIOD_CYCLES - 1)
                    w_state_nxt = r_enable ? c_TRIG : c_IDLE;
            end
            default: w_state_nxt = c_IDLE;
        endcase
    end

    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            r_state      <= c_IDLE;
            r_trig       <= 1'b0;
            r_cyc_cnt    <= '0;
            r_period_cnt <= '0;
            r_echo_cnt   <= '0;
            r_sub        <= '0;
            r_cm         <= '0;
        end else begin
            r_state <= w_state_nxt;
            // Registered from the next state so trig is glitch-free and
            // exactly as long as the TRIG state.
            r_trig  <= (w_state_nxt == c_TRIG);

            // Per-state cycle counter restarts on every state change.
            if (w_state_nxt != r_state) r_cyc_cnt <= '0;
            else                        r_cyc_cnt <= r_cyc_cnt + 32'd1;

            if (r_state == c_IDLE || (w_state_nxt == c_TRIG && r_state != c_TRIG))
                r_period_cnt <= '0;
            else
                r_period_cnt <= r_period_cnt + 32'd1;

            if (r_state == c_MEASURE) begin
                r_echo_cnt <= w_echo_inc;
                r_sub      <= w_sub_inc;
                r_cm       <= w_cm_inc;
            end else begin
                r_echo_cnt <= '0;
                r_sub      <= '0;
                r_cm       <= '0;
            end
        end
    end

    assign w_ctrl_wr = avs_write && (avs_address == 2'd0);
    assign w_dist_rd = avs_read && (avs_address == 2'd1);

    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            r_enable     <= 1'b0;
            r_irq_en     <= 1'b0;
            r_valid      <= 1'b0;
            r_timeout    <= 1'b0;
            r_dist_cm    <= '0;
            r_echo_cyc   <= '0;
            r_meas_cnt   <= '0;
            avs_readdata <= '0;
        end else begin
            if (w_ctrl_wr) begin
                r_enable <= avs_writedata[0];
                r_irq_en <= avs_writedata[1];
            end
            // Hardware set wins over software clear for both flags.
            r_timeout <= w_timeout_set | (r_timeout & ~(w_ctrl_wr & avs_writedata[9]));
            r_valid   <= w_result | (r_valid & ~w_dist_rd);
            if (w_result) begin
                r_dist_cm  <= w_cm_inc;
                r_echo_cyc <= w_echo_inc;
                r_meas_cnt <= r_meas_cnt + 16'd1;
            end
            if (avs_read) begin
                case (avs_address)
                    2'd0:    avs_readdata <= {22'd0, r_timeout, r_valid, 6'd0, r_irq_en, r_enable};
                    2'd1:    avs_readdata <= {16'd0, r_dist_cm};
                    2'd2:    avs_readdata <= {8'd0, r_echo_cyc};
                    default: avs_readdata <= {16'd0, r_meas_cnt};
                endcase
            end
        end
    end

    assign trig = r_trig;
    assign irq  = r_valid & r_irq_en;

endmodule
`default_nettype wire

// File: tb/tb_ultrasonic_ranger.sv
`default_nettype none
// ============================================================================
// Module      : tb_ultrasonic_ranger
// Description : Directed self-checking bench for ultrasonic_ranger using
//               short simulation timing parameters.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ultrasonic_ranger;

    localparam int unsigned c_TRIG    = 5;
    localparam int unsigned c_PERIOD  = 200;
    localparam int unsigned c_TIMEOUT = 100;
    localparam int unsigned c_CM_DIV  = 10;

    logic        clk_clk = 1'b0;
    logic        reset_reset_n;
    logic        echo;
    logic        trig;
    logic [1:0]  avs_address;
    logic        avs_read;
    logic        avs_write;
    logic [31:0] avs_writedata;
    logic [31:0] avs_readdata;
    logic        irq;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk_clk = ~clk_clk;

    ultrasonic_ranger #(
        .TRIG_CYCLES    (c_TRIG),
        .PERIOD_CYCLES  (c_PERIOD),
        .TIMEOUT_CYCLES (c_TIMEOUT),
        .CM_DIV         (c_CM_DIV)
    ) u_dut (
        .clk_clk       (clk_clk),
        .reset_reset_n (reset_reset_n),
        .echo          (echo),
        .trig          (trig),
        .avs_address   (avs_address),
        .avs_read      (avs_read),
        .avs_write     (avs_write),
        .avs_writedata (avs_writedata),
        .avs_readdata  (avs_readdata),
        .irq           (irq)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_clk);
        #1;
    endtask

    task automatic bus_write(input logic [1:0] addr, input logic [31:0] data);
        avs_address   = addr;
        avs_writedata = data;
        avs_write     = 1'b1;
        tick();
        avs_write     = 1'b0;
    endtask

    task automatic check_reg(input string tag, input logic [1:0] addr, input logic [31:0] exp);
        avs_address = addr;
        avs_read    = 1'b1;
        tick();
        avs_read    = 1'b0;
        check(tag, avs_readdata, exp);
    endtask

    task automatic wait_trig(input logic lvl);
        int k;
        k = 0;
        while (trig !== lvl && k < 1000) begin
            tick();
            k++;
        end
        if (trig !== lvl) check("trig_wait", {31'd0, trig}, {31'd0, lvl});
    endtask

    // Echo pulse of n cycles starting shortly after the next trigger ends.
    task automatic pulse_echo(input int n);
        wait_trig(1'b1);
        wait_trig(1'b0);
        repeat (3) tick();
        echo = 1'b1;
        repeat (n) tick();
        echo = 1'b0;
        repeat (6) tick();
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int k;
        int rises;
        logic prev;

        reset_reset_n = 1'b0;
        echo          = 1'b0;
        avs_address   = 2'd0;
        avs_read      = 1'b0;
        avs_write     = 1'b0;
        avs_writedata = 32'd0;
        repeat (3) tick();
        check("rst_trig", {31'd0, trig}, 32'd0);
        check("rst_irq", {31'd0, irq}, 32'd0);
        check("rst_rdata", avs_readdata, 32'd0);
        reset_reset_n = 1'b1;
        tick();
        check_reg("rst_ctrl", 2'd0, 32'd0);
        check_reg("rst_dist", 2'd1, 32'd0);
        check_reg("rst_echo", 2'd2, 32'd0);
        check_reg("rst_meas", 2'd3, 32'd0);

        // Trigger width and trigger-to-trigger spacing (no echo: timeout).
        bus_write(2'd0, 32'h1);
        wait_trig(1'b1);
        k = 0;
        while (trig === 1'b1 && k < 1000) begin tick(); k++; end
        check("trig_width", 32'(k), 32'd5);
        while (trig === 1'b0 && k < 1000) begin tick(); k++; end
        check("trig_period", 32'(k), 32'd200);

        // 47-cycle echo during the second cycle.
        pulse_echo(47);
        check_reg("ctrl_valid_to", 2'd0, 32'h301);
        check_reg("dist_47", 2'd1, 32'd4);
        check_reg("ctrl_valid_clr", 2'd0, 32'h201);
        bus_write(2'd0, 32'h201);
        check_reg("ctrl_to_w1c", 2'd0, 32'h001);
        check_reg("echo_47", 2'd2, 32'd47);
        check_reg("meas_1", 2'd3, 32'd1);
        bus_write(2'd1, 32'hFFFF);
        check_reg("dist_wr_ignored", 2'd1, 32'd4);

        // Exact multiple of CM_DIV, then below one centimetre.
        pulse_echo(50);
        check_reg("dist_50", 2'd1, 32'd5);
        check_reg("echo_50", 2'd2, 32'd50);
        check_reg("meas_2", 2'd3, 32'd2);
        pulse_echo(9);
        check_reg("ctrl_valid_9", 2'd0, 32'h101);
        check_reg("dist_9", 2'd1, 32'd0);
        check_reg("echo_9", 2'd2, 32'd9);
        check_reg("meas_3", 2'd3, 32'd3);

        // Echo longer than the timeout.
        pulse_echo(150);
        check_reg("ctrl_long_to", 2'd0, 32'h201);
        check_reg("dist_long_kept", 2'd1, 32'd0);
        check_reg("echo_long_kept", 2'd2, 32'd9);
        check_reg("meas_long", 2'd3, 32'd3);

        // Disable during MEASURE (also clears timeout).
        wait_trig(1'b1);
        wait_trig(1'b0);
        repeat (3) tick();
        echo = 1'b1;
        for (int i = 0; i < 30; i++) begin
            if (i == 10) begin
                avs_address   = 2'd0;
                avs_writedata = 32'h200;
                avs_write     = 1'b1;
            end
            if (i == 11) avs_write = 1'b0;
            tick();
        end
        echo  = 1'b0;
        rises = 0;
        prev  = trig;
        for (int i = 0; i < 250; i++) begin
            tick();
            if (trig === 1'b1 && prev === 1'b0) rises++;
            prev = trig;
        end
        check("no_trig_disabled", 32'(rises), 32'd0);
        check_reg("ctrl_disabled", 2'd0, 32'h100);
        check_reg("dist_disabled", 2'd1, 32'd3);
        check_reg("echo_disabled", 2'd2, 32'd30);
        check_reg("meas_4", 2'd3, 32'd4);

        // Interrupt with a 30-cycle echo.
        bus_write(2'd0, 32'h3);
        check("irq_idle", {31'd0, irq}, 32'd0);
        wait_trig(1'b1);
        wait_trig(1'b0);
        repeat (3) tick();
        echo = 1'b1;
        repeat (30) tick();
        echo = 1'b0;
        repeat (2) tick();
        check("irq_early", {31'd0, irq}, 32'd0);
        tick();
        check("irq_rise", {31'd0, irq}, 32'd1);
        check_reg("ctrl_irq", 2'd0, 32'h103);
        check_reg("dist_irq", 2'd1, 32'd3);
        check("irq_cleared", {31'd0, irq}, 32'd0);
        check_reg("meas_5", 2'd3, 32'd5);

        // Asynchronous reset in the middle of a trigger pulse.
        wait_trig(1'b1);
        tick();
        tick();
        reset_reset_n = 1'b0;
        #1;
        check("trig_async_rst", {31'd0, trig}, 32'd0);
        check("rdata_async_rst", avs_readdata, 32'd0);
        tick();
        reset_reset_n = 1'b1;
        tick();
        check_reg("post_rst_ctrl", 2'd0, 32'd0);
        check_reg("post_rst_dist", 2'd1, 32'd0);
        check_reg("post_rst_echo", 2'd2, 32'd0);
        check_reg("post_rst_meas", 2'd3, 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
